// File: rtl/nodf_mon_pkg.sv
// Shared types and constants for the ap_ctrl_hs status monitor.
package nodf_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_STALL    = 2'd2,
        ST_FINISHED = 2'd3
    } mon_status_e;

    localparam logic [63:0] LAT_INIT_MIN = '1;

endpackage

// File: rtl/nodf_ts_fifo.sv
// Timestamp FIFO, first-word fall-through; pop+push in one cycle is legal when full.
module nodf_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign dout   = r_mem[r_rd];
    assign w_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/nodf_module_intf.sv
// Passive ap_ctrl_hs monitor: counts starts/completions, measures latency, tracks busy/stall time
// and protocol errors. All outputs registered; freezes once finish is seen until reset.
module nodf_module_intf
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] n_start,
    output logic [CNT_W-1:0] n_done,
    output logic [CW-1:0]    in_flight,
    output logic [CNT_W-1:0] last_lat,
    output logic [CNT_W-1:0] min_lat,
    output logic [CNT_W-1:0] max_lat,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic             sample_valid
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    mon_status_e      r_status, w_status_nxt;
    logic [CNT_W-1:0] r_cyc, r_n_start, r_n_done, r_last, r_min, r_max, r_busy, r_stall;
    logic             r_ovf, r_unf, r_sample;

    logic             w_frozen, w_s, w_d, w_stall, w_zero, w_pop, w_push, w_ovf, w_unf;
    logic             w_full, w_empty, w_sample;
    logic [CNT_W-1:0] w_ts, w_lat;
    logic [CW-1:0]    w_count, w_inflight_nxt;

    assign w_frozen = (r_status == ST_FINISHED) | finish;
    assign w_s      = ap_start & ap_ready;
    assign w_d      = ap_done & ap_continue;
    assign w_stall  = ap_done & ~ap_continue;
    // S and D on an empty FIFO form a zero-latency transaction that never touches the FIFO.
    assign w_zero   = w_s & w_d & w_empty & ~w_frozen;
    assign w_pop    = w_d & ~w_empty & ~w_frozen;
    assign w_push   = w_s & ~(w_d & w_empty) & (~w_full | w_d) & ~w_frozen;
    assign w_ovf    = w_s & w_full & ~w_d & ~w_frozen;
    assign w_unf    = w_d & w_empty & ~w_s & ~w_frozen;
    assign w_sample = w_pop | w_zero;
    assign w_lat    = w_pop ? (r_cyc - w_ts) : '0;

    nodf_ts_fifo #(.DEPTH(DEPTH), .W(CNT_W)) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_cyc),
        .dout  (w_ts),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_inflight_nxt = w_count;
        if (w_push && !w_pop)      w_inflight_nxt = w_count + CW'(1);
        else if (w_pop && !w_push) w_inflight_nxt = w_count - CW'(1);
    end

    always_comb begin
        w_status_nxt = ST_IDLE;
        if (w_frozen)                  w_status_nxt = ST_FINISHED;
        else if (w_stall)              w_status_nxt = ST_STALL;
        else if (w_inflight_nxt != '0) w_status_nxt = ST_BUSY;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_status  <= ST_IDLE;
            r_cyc     <= '0;
            r_n_start <= '0;
            r_n_done  <= '0;
            r_last    <= '0;
            r_min     <= CNT_W'(LAT_INIT_MIN);
            r_max     <= '0;
            r_busy    <= '0;
            r_stall   <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_sample  <= 1'b0;
        end else begin
            r_status <= w_status_nxt;
            r_sample <= w_sample;
            if (!w_frozen) begin
                r_cyc <= r_cyc + ONE;
                if (w_push | w_zero) r_n_start <= r_n_start + ONE;
                if (w_sample) begin
                    r_n_done <= r_n_done + ONE;
                    r_last   <= w_lat;
                    if (w_lat < r_min) r_min <= w_lat;
                    if (w_lat > r_max) r_max <= w_lat;
                end
                if (r_status == ST_BUSY || r_status == ST_STALL) r_busy <= r_busy + ONE;
                if (w_stall) r_stall <= r_stall + ONE;
                if (w_ovf)   r_ovf   <= 1'b1;
                if (w_unf)   r_unf   <= 1'b1;
            end
        end
    end

    assign status        = r_status;
    assign n_start       = r_n_start;
    assign n_done        = r_n_done;
    assign in_flight     = w_count;
    assign last_lat      = r_last;
    assign min_lat       = r_min;
    assign max_lat       = r_max;
    assign busy_cycles   = r_busy;
    assign stall_cycles  = r_stall;
    assign err_overflow  = r_ovf;
    assign err_underflow = r_unf;
    assign sample_valid  = r_sample;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed bench for the ap_ctrl_hs monitor with hand-computed expectations.
module tb_nodf_module_intf;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0, ap_ready = 1'b1, ap_done = 1'b0, ap_continue = 1'b1, finish = 1'b0;
    logic [1:0]  status;
    logic [31:0] n_start, n_done, last_lat, min_lat, max_lat, busy_cycles, stall_cycles;
    logic [2:0]  in_flight;
    logic        err_overflow, err_underflow, sample_valid;

    int total = 0;
    int bad   = 0;
    int sv_cnt = 0;
    int sv0;

    nodf_module_intf #(.CNT_W(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .status(status), .n_start(n_start), .n_done(n_done), .in_flight(in_flight),
        .last_lat(last_lat), .min_lat(min_lat), .max_lat(max_lat),
        .busy_cycles(busy_cycles), .stall_cycles(stall_cycles),
        .err_overflow(err_overflow), .err_underflow(err_underflow), .sample_valid(sample_valid)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (sample_valid === 1'b1) sv_cnt++;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_in();
        ap_start = 1'b0; ap_ready = 1'b1; ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        sv0 = sv_cnt;
        step(10);
        total++; if (status !== 2'd0) begin bad++; $display("FAIL reset_status got=%0d exp=0", status); end
        total++; if (n_start !== 32'd0) begin bad++; $display("FAIL reset_nstart got=%0d exp=0", n_start); end
        total++; if (n_done !== 32'd0) begin bad++; $display("FAIL reset_ndone got=%0d exp=0", n_done); end
        total++; if (in_flight !== 3'd0) begin bad++; $display("FAIL reset_inflight got=%0d exp=0", in_flight); end
        total++; if (min_lat !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_min got=%0h exp=ffffffff", min_lat); end
        total++; if (max_lat !== 32'd0 || last_lat !== 32'd0) begin bad++; $display("FAIL reset_lat got=%0d/%0d exp=0/0", max_lat, last_lat); end
        total++; if (busy_cycles !== 32'd0 || stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_busy_stall got=%0d/%0d exp=0/0", busy_cycles, stall_cycles); end
        total++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", err_overflow, err_underflow); end
        total++; if (sv_cnt != sv0) begin bad++; $display("FAIL reset_sample got=%0d exp=0 pulses", sv_cnt - sv0); end
    endtask

    task automatic test_single();
        do_reset();
        ap_start = 1'b1; step(); ap_start = 1'b0;
        total++; if (status !== 2'd1) begin bad++; $display("FAIL single_busy got=%0d exp=1", status); end
        step(6);
        ap_done = 1'b1; step(); ap_done = 1'b0;
        total++; if (sample_valid !== 1'b1) begin bad++; $display("FAIL single_sv got=%b exp=1", sample_valid); end
        total++; if (last_lat !== 32'd7 || min_lat !== 32'd7 || max_lat !== 32'd7) begin bad++; $display("FAIL single_lat got=%0d/%0d/%0d exp=7/7/7", last_lat, min_lat, max_lat); end
        total++; if (n_start !== 32'd1 || n_done !== 32'd1) begin bad++; $display("FAIL single_counts got=%0d/%0d exp=1/1", n_start, n_done); end
        total++; if (busy_cycles !== 32'd7) begin bad++; $display("FAIL single_busy_cycles got=%0d exp=7", busy_cycles); end
        step();
        total++; if (sample_valid !== 1'b0 || status !== 2'd0) begin bad++; $display("FAIL single_after got=%b/%0d exp=0/0", sample_valid, status); end
    endtask

    task automatic test_pipelined();
        do_reset();
        ap_start = 1'b1; step(3); ap_start = 1'b0;
        total++; if (in_flight !== 3'd3) begin bad++; $display("FAIL pipe_peak got=%0d exp=3", in_flight); end
        step(5);
        ap_done = 1'b1; step(3); ap_done = 1'b0;
        total++; if (last_lat !== 32'd8 || min_lat !== 32'd8 || max_lat !== 32'd8) begin bad++; $display("FAIL pipe_lat got=%0d/%0d/%0d exp=8/8/8", last_lat, min_lat, max_lat); end
        total++; if (n_done !== 32'd3 || in_flight !== 3'd0) begin bad++; $display("FAIL pipe_done got=%0d/%0d exp=3/0", n_done, in_flight); end
        ap_start = 1'b1; step(); ap_start = 1'b0; step(4);
        ap_done = 1'b1; step(); ap_done = 1'b0;
        ap_start = 1'b1; step(); ap_start = 1'b0; step(8);
        ap_done = 1'b1; step(); ap_done = 1'b0;
        total++; if (min_lat !== 32'd5 || max_lat !== 32'd9 || last_lat !== 32'd9) begin bad++; $display("FAIL pipe_minmax got=%0d/%0d/%0d exp=5/9/9", min_lat, max_lat, last_lat); end
        total++; if (n_done !== 32'd5) begin bad++; $display("FAIL pipe_ndone got=%0d exp=5", n_done); end
    endtask

    task automatic test_full_tiebreak();
        do_reset();
        ap_start = 1'b1; step(4);
        total++; if (in_flight !== 3'd4) begin bad++; $display("FAIL tie_full got=%0d exp=4", in_flight); end
        ap_done = 1'b1; step(); ap_start = 1'b0; ap_done = 1'b0;
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL tie_ovf got=%b exp=0", err_overflow); end
        total++; if (in_flight !== 3'd4 || n_start !== 32'd5 || n_done !== 32'd1) begin bad++; $display("FAIL tie_counts got=%0d/%0d/%0d exp=4/5/1", in_flight, n_start, n_done); end
        total++; if (last_lat !== 32'd4) begin bad++; $display("FAIL tie_lat got=%0d exp=4", last_lat); end
    endtask

    task automatic test_overflow();
        do_reset();
        ap_start = 1'b1; step(5); ap_start = 1'b0;
        total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", err_overflow); end
        total++; if (n_start !== 32'd4 || in_flight !== 3'd4) begin bad++; $display("FAIL ovf_counts got=%0d/%0d exp=4/4", n_start, in_flight); end
    endtask

    task automatic test_underflow();
        do_reset();
        sv0 = sv_cnt;
        ap_done = 1'b1; step(); ap_done = 1'b0; step();
        total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", err_underflow); end
        total++; if (n_done !== 32'd0 || sv_cnt != sv0) begin bad++; $display("FAIL unf_quiet got=%0d/%0d exp=0/0", n_done, sv_cnt - sv0); end
        ap_start = 1'b1; ap_done = 1'b1; step(); ap_start = 1'b0; ap_done = 1'b0;
        total++; if (sample_valid !== 1'b1 || last_lat !== 32'd0 || min_lat !== 32'd0) begin bad++; $display("FAIL zero_lat got=%b/%0d/%0d exp=1/0/0", sample_valid, last_lat, min_lat); end
        total++; if (n_start !== 32'd1 || n_done !== 32'd1 || in_flight !== 3'd0) begin bad++; $display("FAIL zero_counts got=%0d/%0d/%0d exp=1/1/0", n_start, n_done, in_flight); end
    endtask

    task automatic test_stall();
        do_reset();
        ap_start = 1'b1; step(); ap_start = 1'b0;
        ap_done = 1'b1; ap_continue = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (status !== 2'd2) begin bad++; $display("FAIL stall_status%0d got=%0d exp=2", i, status); end
        end
        total++; if (stall_cycles !== 32'd3 || n_done !== 32'd0) begin bad++; $display("FAIL stall_count got=%0d/%0d exp=3/0", stall_cycles, n_done); end
        ap_continue = 1'b1; step(); ap_done = 1'b0;
        total++; if (n_done !== 32'd1 || last_lat !== 32'd4) begin bad++; $display("FAIL stall_done got=%0d/%0d exp=1/4", n_done, last_lat); end
        total++; if (status !== 2'd0 || stall_cycles !== 32'd3) begin bad++; $display("FAIL stall_after got=%0d/%0d exp=0/3", status, stall_cycles); end
    endtask

    task automatic test_finish();
        do_reset();
        ap_start = 1'b1; step(); ap_start = 1'b0; step();
        total++; if (status !== 2'd1) begin bad++; $display("FAIL fin_busy got=%0d exp=1", status); end
        finish = 1'b1; step(); finish = 1'b0;
        total++; if (status !== 2'd3) begin bad++; $display("FAIL fin_state got=%0d exp=3", status); end
        sv0 = sv_cnt;
        ap_start = 1'b1; ap_done = 1'b1; step(3); ap_start = 1'b0; ap_done = 1'b0; step();
        total++; if (status !== 2'd3 || n_start !== 32'd1 || n_done !== 32'd0 || in_flight !== 3'd1) begin bad++; $display("FAIL fin_frozen got=%0d/%0d/%0d/%0d exp=3/1/0/1", status, n_start, n_done, in_flight); end
        total++; if (sv_cnt != sv0 || min_lat !== 32'hFFFF_FFFF) begin bad++; $display("FAIL fin_nosample got=%0d/%0h exp=0/ffffffff", sv_cnt - sv0, min_lat); end
        reset = 1'b1; #2;
        total++; if (status !== 2'd0 || n_start !== 32'd0 || in_flight !== 3'd0) begin bad++; $display("FAIL fin_reset got=%0d/%0d/%0d exp=0/0/0", status, n_start, in_flight); end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ap_start = 1'b1; step(5);
        ap_done = 1'b1; step();
        reset = 1'b1; #2;
        total++; if (status !== 2'd0 || n_start !== 32'd0 || n_done !== 32'd0 || in_flight !== 3'd0) begin bad++; $display("FAIL mid_counts got=%0d/%0d/%0d/%0d exp=0/0/0/0", status, n_start, n_done, in_flight); end
        total++; if (err_overflow !== 1'b0 || busy_cycles !== 32'd0 || min_lat !== 32'hFFFF_FFFF || last_lat !== 32'd0) begin bad++; $display("FAIL mid_state got=%b/%0d/%0h/%0d exp=0/0/ffffffff/0", err_overflow, busy_cycles, min_lat, last_lat); end
        idle_in();
        reset = 1'b0;
        step(2);
        total++; if (status !== 2'd0 || n_start !== 32'd0) begin bad++; $display("FAIL mid_after got=%0d/%0d exp=0/0", status, n_start); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pipelined();
        test_full_tiebreak();
        test_overflow();
        test_underflow();
        test_stall();
        test_finish();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
